// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared widths, opcodes, state and skid-entry types for the ALU issue stage
package alu_pkg;

    localparam int DATA_W = 16;
    localparam int REG_AW = 3;
    localparam int OP_W   = 3;

    localparam logic [OP_W-1:0] ALU_NOP = 3'd0;
    localparam logic [OP_W-1:0] ALU_ADD = 3'd1;
    localparam logic [OP_W-1:0] ALU_SUB = 3'd2;
    localparam logic [OP_W-1:0] ALU_OR  = 3'd3;
    localparam logic [OP_W-1:0] ALU_AND = 3'd4;
    localparam logic [OP_W-1:0] ALU_SHL = 3'd5;
    localparam logic [OP_W-1:0] ALU_SHR = 3'd6;
    localparam logic [OP_W-1:0] ALU_XOR = 3'd7;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } issue_state_t;

    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic [REG_AW-1:0] rd;
        logic [DATA_W-1:0] rs1d;
        logic [DATA_W-1:0] rs2d;
        logic [DATA_W-1:0] imm;
        logic              useimm;
        logic              we;
    } issue_op_t;

endpackage

// File: rtl/alu_fwd_mux.sv
// rtl/alu_fwd_mux.sv - priority operand select for one source: R0, then EX, then WB, then regfile
module alu_fwd_mux
    import alu_pkg::*;
(
    input  logic [REG_AW-1:0] src,
    input  logic [DATA_W-1:0] raw,
    input  logic              ex_en,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic [DATA_W-1:0] ex_data,
    input  logic              wb_en,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic [DATA_W-1:0] wb_data,
    output logic [DATA_W-1:0] data
);

    always_comb begin
        data = raw;
        if (src == '0) begin
            data = '0;
        end else if (ex_en && (ex_rd == src)) begin
            data = ex_data;
        end else if (wb_en && (wb_rd == src)) begin
            data = wb_data;
        end
    end

endmodule

// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - ALU issue stage with operand forwarding and 2-entry skid buffer
// Optional perf counters (IssueCount/StallCount) are built when ALU_ISSUE_PERF_EN is defined.
module alu_issue_stage
    import alu_pkg::*;
(
    input  logic              Clock,
    input  logic              ResetN,
    input  logic              Flush,
    input  logic              InValid,
    output logic              InReady,
    input  logic [OP_W-1:0]   InALUOp,
    input  logic [REG_AW-1:0] InRs1,
    input  logic [REG_AW-1:0] InRs2,
    input  logic [REG_AW-1:0] InRd,
    input  logic [DATA_W-1:0] InRs1Data,
    input  logic [DATA_W-1:0] InRs2Data,
    input  logic [DATA_W-1:0] InImm,
    input  logic              InUseImm,
    input  logic              InWriteEn,
    input  logic [DATA_W-1:0] ExResult,
    input  logic              WbValid,
    input  logic [REG_AW-1:0] WbRd,
    input  logic [DATA_W-1:0] WbData,
    output logic              OutValid,
    input  logic              OutReady,
    output logic [DATA_W-1:0] FirstInput,
    output logic [DATA_W-1:0] SecondInput,
    output logic [OP_W-1:0]   ALUOp,
    output logic [REG_AW-1:0] OutRd,
    output logic              OutWriteEn
`ifdef ALU_ISSUE_PERF_EN
    ,
    output logic [15:0]       IssueCount,
    output logic [15:0]       StallCount
`endif
);

    issue_state_t state_q, state_d;
    issue_op_t    skid_q;
    issue_op_t    in_op;
    issue_op_t    src_op;
    logic         in_ready_q;
    logic         accept, consume;
    logic         load_out, load_from_skid, load_skid;
    logic [DATA_W-1:0] fwd_a, fwd_b;

    assign OutValid = (state_q != ST_EMPTY);
    assign InReady  = in_ready_q;
    assign accept   = InValid && in_ready_q;
    assign consume  = OutValid && OutReady;

    always_comb begin
        in_op.op     = InALUOp;
        in_op.rs1    = InRs1;
        in_op.rs2    = InRs2;
        in_op.rd     = InRd;
        in_op.rs1d   = InRs1Data;
        in_op.rs2d   = InRs2Data;
        in_op.imm    = InImm;
        in_op.useimm = InUseImm;
        in_op.we     = InWriteEn;
    end

    always_comb begin
        state_d        = state_q;
        load_out       = 1'b0;
        load_from_skid = 1'b0;
        load_skid      = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    state_d  = ST_ONE;
                    load_out = 1'b1;
                end
            end
            ST_ONE: begin
                if (accept && consume) begin
                    load_out = 1'b1;
                end else if (accept) begin
                    state_d   = ST_FULL;
                    load_skid = 1'b1;
                end else if (consume) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (consume) begin
                    state_d        = ST_ONE;
                    load_out       = 1'b1;
                    load_from_skid = 1'b1;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        // Flush wins over any accept or consume in the same cycle.
        if (Flush) begin
            state_d        = ST_EMPTY;
            load_out       = 1'b0;
            load_from_skid = 1'b0;
            load_skid      = 1'b0;
        end
    end

    assign src_op = load_from_skid ? skid_q : in_op;

    // Skid data is raw; it is resolved only when it moves into the output register.
    alu_fwd_mux u_fwd_a (
        .src     (src_op.rs1),
        .raw     (src_op.rs1d),
        .ex_en   (consume && OutWriteEn),
        .ex_rd   (OutRd),
        .ex_data (ExResult),
        .wb_en   (WbValid),
        .wb_rd   (WbRd),
        .wb_data (WbData),
        .data    (fwd_a)
    );

    alu_fwd_mux u_fwd_b (
        .src     (src_op.rs2),
        .raw     (src_op.rs2d),
        .ex_en   (consume && OutWriteEn),
        .ex_rd   (OutRd),
        .ex_data (ExResult),
        .wb_en   (WbValid),
        .wb_rd   (WbRd),
        .wb_data (WbData),
        .data    (fwd_b)
    );

    always_ff @(posedge Clock) begin
        if (!ResetN) begin
            state_q     <= ST_EMPTY;
            in_ready_q  <= 1'b1;
            skid_q      <= '0;
            FirstInput  <= '0;
            SecondInput <= '0;
            ALUOp       <= '0;
            OutRd       <= '0;
            OutWriteEn  <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != ST_FULL);
            if (load_skid) begin
                skid_q <= in_op;
            end
            if (Flush) begin
                ALUOp      <= '0;
                OutWriteEn <= 1'b0;
            end else if (load_out) begin
                FirstInput  <= fwd_a;
                SecondInput <= src_op.useimm ? src_op.imm : fwd_b;
                ALUOp       <= src_op.op;
                OutRd       <= src_op.rd;
                OutWriteEn  <= src_op.we;
            end
        end
    end

`ifdef ALU_ISSUE_PERF_EN
    always_ff @(posedge Clock) begin
        if (!ResetN) begin
            IssueCount <= '0;
            StallCount <= '0;
        end else begin
            if (consume && (IssueCount != 16'hFFFF)) begin
                IssueCount <= IssueCount + 16'd1;
            end
            if (OutValid && !OutReady && (StallCount != 16'hFFFF)) begin
                StallCount <= StallCount + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb/tb_alu_issue_stage.sv - directed table-driven bench for alu_issue_stage
module tb_alu_issue_stage;

    logic        Clock = 1'b0;
    logic        ResetN = 1'b0;
    logic        Flush = 1'b0;
    logic        InValid = 1'b0;
    logic        InReady;
    logic [2:0]  InALUOp = '0;
    logic [2:0]  InRs1 = '0, InRs2 = '0, InRd = '0;
    logic [15:0] InRs1Data = '0, InRs2Data = '0, InImm = '0;
    logic        InUseImm = 1'b0;
    logic        InWriteEn = 1'b0;
    logic [15:0] ExResult = '0;
    logic        WbValid = 1'b0;
    logic [2:0]  WbRd = '0;
    logic [15:0] WbData = '0;
    logic        OutValid;
    logic        OutReady = 1'b0;
    logic [15:0] FirstInput, SecondInput;
    logic [2:0]  ALUOp;
    logic [2:0]  OutRd;
    logic        OutWriteEn;
`ifdef ALU_ISSUE_PERF_EN
    logic [15:0] IssueCount, StallCount;
`endif

    int checks = 0;
    int failures = 0;

    alu_issue_stage dut (
        .Clock       (Clock),
        .ResetN      (ResetN),
        .Flush       (Flush),
        .InValid     (InValid),
        .InReady     (InReady),
        .InALUOp     (InALUOp),
        .InRs1       (InRs1),
        .InRs2       (InRs2),
        .InRd        (InRd),
        .InRs1Data   (InRs1Data),
        .InRs2Data   (InRs2Data),
        .InImm       (InImm),
        .InUseImm    (InUseImm),
        .InWriteEn   (InWriteEn),
        .ExResult    (ExResult),
        .WbValid     (WbValid),
        .WbRd        (WbRd),
        .WbData      (WbData),
        .OutValid    (OutValid),
        .OutReady    (OutReady),
        .FirstInput  (FirstInput),
        .SecondInput (SecondInput),
        .ALUOp       (ALUOp),
        .OutRd       (OutRd),
        .OutWriteEn  (OutWriteEn)
`ifdef ALU_ISSUE_PERF_EN
        ,
        .IssueCount  (IssueCount),
        .StallCount  (StallCount)
`endif
    );

    always #5 Clock = ~Clock;

    typedef struct {
        logic [2:0]  op;
        logic [2:0]  rs1;
        logic [15:0] rs1d;
        logic [2:0]  rs2;
        logic [15:0] rs2d;
        logic [2:0]  rd;
        logic        we;
        logic        useimm;
        logic [15:0] imm;
        logic        wbv;
        logic [2:0]  wbrd;
        logic [15:0] wbdata;
        logic [15:0] exp_a;
        logic [15:0] exp_b;
    } vec_t;

    vec_t vecs[6];

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_in(input logic [2:0] op, input logic [2:0] r1, input logic [15:0] d1,
                          input logic [2:0] r2, input logic [15:0] d2, input logic [2:0] rd,
                          input logic we, input logic ui, input logic [15:0] imm);
        InALUOp   = op;
        InRs1     = r1;
        InRs1Data = d1;
        InRs2     = r2;
        InRs2Data = d2;
        InRd      = rd;
        InWriteEn = we;
        InUseImm  = ui;
        InImm     = imm;
    endtask

    initial begin
        vecs[0] = '{3'd1, 3'd2, 16'h0005, 3'd3, 16'h0003, 3'd1, 1'b0, 1'b0, 16'h0000,
                    1'b0, 3'd0, 16'h0000, 16'h0005, 16'h0003};
        vecs[1] = '{3'd2, 3'd0, 16'h2222, 3'd5, 16'h1111, 3'd2, 1'b1, 1'b0, 16'h0000,
                    1'b1, 3'd5, 16'hBEEF, 16'h0000, 16'hBEEF};
        vecs[2] = '{3'd3, 3'd0, 16'h3333, 3'd1, 16'h0101, 3'd3, 1'b0, 1'b0, 16'h0000,
                    1'b1, 3'd0, 16'h1234, 16'h0000, 16'h0101};
        vecs[3] = '{3'd4, 3'd5, 16'h0000, 3'd5, 16'h0000, 3'd4, 1'b1, 1'b1, 16'h0007,
                    1'b1, 3'd5, 16'hBEEF, 16'hBEEF, 16'h0007};
        vecs[4] = '{3'd0, 3'd7, 16'hFFFF, 3'd7, 16'hFFFF, 3'd6, 1'b1, 1'b0, 16'h0000,
                    1'b1, 3'd6, 16'h5A5A, 16'hFFFF, 16'hFFFF};
        vecs[5] = '{3'd7, 3'd3, 16'hC0DE, 3'd4, 16'h00A0, 3'd7, 1'b0, 1'b0, 16'h0000,
                    1'b0, 3'd3, 16'h9999, 16'hC0DE, 16'h00A0};

        // reset
        ResetN = 1'b0;
        step();
        step();
        check("rst_outvalid", OutValid, 0);
        check("rst_inready", InReady, 1);
        check("rst_first", FirstInput, 0);
        check("rst_second", SecondInput, 0);
        check("rst_aluop", ALUOp, 0);
        check("rst_outrd", OutRd, 0);
        check("rst_we", OutWriteEn, 0);
        ResetN = 1'b1;
        step();

        // single-op vectors from EMPTY
        OutReady = 1'b1;
        for (int i = 0; i < 6; i++) begin
            set_in(vecs[i].op, vecs[i].rs1, vecs[i].rs1d, vecs[i].rs2, vecs[i].rs2d,
                   vecs[i].rd, vecs[i].we, vecs[i].useimm, vecs[i].imm);
            WbValid = vecs[i].wbv;
            WbRd    = vecs[i].wbrd;
            WbData  = vecs[i].wbdata;
            InValid = 1'b1;
            step();
            InValid = 1'b0;
            WbValid = 1'b0;
            check($sformatf("v%0d_valid", i), OutValid, 1);
            check($sformatf("v%0d_first", i), FirstInput, vecs[i].exp_a);
            check($sformatf("v%0d_second", i), SecondInput, vecs[i].exp_b);
            check($sformatf("v%0d_aluop", i), ALUOp, vecs[i].op);
            check($sformatf("v%0d_rd", i), OutRd, vecs[i].rd);
            check($sformatf("v%0d_we", i), OutWriteEn, vecs[i].we);
            step();
            check($sformatf("v%0d_drain", i), OutValid, 0);
        end

        // back-to-back EX forward, EX beats WB on the same index
        set_in(3'd1, 3'd1, 16'h0001, 3'd2, 16'h0002, 3'd4, 1'b1, 1'b0, 16'h0000);
        InValid = 1'b1;
        step();
        set_in(3'd2, 3'd4, 16'h0000, 3'd4, 16'h0000, 3'd5, 1'b0, 1'b0, 16'h0000);
        ExResult = 16'h0042;
        WbValid  = 1'b1;
        WbRd     = 3'd4;
        WbData   = 16'h9999;
        step();
        InValid  = 1'b0;
        WbValid  = 1'b0;
        ExResult = 16'h0000;
        check("exfwd_valid", OutValid, 1);
        check("exfwd_first", FirstInput, 16'h0042);
        check("exfwd_second", SecondInput, 16'h0042);
        check("exfwd_aluop", ALUOp, 2);
        step();
        check("exfwd_drain", OutValid, 0);

        // backpressure: two accepted, third waits, in-order issue
        OutReady = 1'b0;
        set_in(3'd1, 3'd1, 16'h0011, 3'd1, 16'h0011, 3'd1, 1'b0, 1'b0, 16'h0000);
        InValid = 1'b1;
        step();
        check("bp1_inready", InReady, 1);
        check("bp1_first", FirstInput, 16'h0011);
        set_in(3'd2, 3'd2, 16'h0022, 3'd2, 16'h0022, 3'd2, 1'b0, 1'b0, 16'h0000);
        step();
        check("bp2_inready", InReady, 0);
        check("bp2_first", FirstInput, 16'h0011);
        check("bp2_aluop", ALUOp, 1);
        set_in(3'd3, 3'd3, 16'h0033, 3'd3, 16'h0033, 3'd3, 1'b0, 1'b0, 16'h0000);
        step();
        check("bp3_inready", InReady, 0);
        check("bp3_first", FirstInput, 16'h0011);
        check("bp3_aluop", ALUOp, 1);
        OutReady = 1'b1;
        step();
        check("bp4_valid", OutValid, 1);
        check("bp4_first", FirstInput, 16'h0022);
        check("bp4_aluop", ALUOp, 2);
        check("bp4_inready", InReady, 1);
        step();
        InValid = 1'b0;
        check("bp5_first", FirstInput, 16'h0033);
        check("bp5_aluop", ALUOp, 3);
        step();
        check("bp6_drain", OutValid, 0);

        // flush while FULL with an op offered
        OutReady = 1'b0;
        set_in(3'd5, 3'd1, 16'h0055, 3'd1, 16'h0055, 3'd1, 1'b1, 1'b0, 16'h0000);
        InValid = 1'b1;
        step();
        set_in(3'd6, 3'd2, 16'h0066, 3'd2, 16'h0066, 3'd2, 1'b1, 1'b0, 16'h0000);
        step();
        check("fl_full", InReady, 0);
        set_in(3'd7, 3'd3, 16'h0077, 3'd3, 16'h0077, 3'd3, 1'b1, 1'b0, 16'h0000);
        Flush = 1'b1;
        step();
        Flush = 1'b0;
        InValid = 1'b0;
        OutReady = 1'b1;
        check("fl_valid", OutValid, 0);
        check("fl_inready", InReady, 1);
        check("fl_aluop", ALUOp, 0);
        check("fl_we", OutWriteEn, 0);
        step();
        check("fl_after1", OutValid, 0);
        step();
        check("fl_after2", OutValid, 0);
        set_in(3'd1, 3'd1, 16'h0088, 3'd1, 16'h0088, 3'd1, 1'b0, 1'b0, 16'h0000);
        InValid = 1'b1;
        step();
        InValid = 1'b0;
        check("fl_next_first", FirstInput, 16'h0088);
        check("fl_next_aluop", ALUOp, 1);
        step();
        check("fl_next_drain", OutValid, 0);

`ifdef ALU_ISSUE_PERF_EN
        ResetN = 1'b0;
        step();
        ResetN = 1'b1;
        check("perf_rst_issue", IssueCount, 0);
        check("perf_rst_stall", StallCount, 0);
        OutReady = 1'b0;
        set_in(3'd1, 3'd1, 16'h0001, 3'd1, 16'h0001, 3'd1, 1'b0, 1'b0, 16'h0000);
        InValid = 1'b1;
        step();
        set_in(3'd2, 3'd2, 16'h0002, 3'd2, 16'h0002, 3'd2, 1'b0, 1'b0, 16'h0000);
        step();
        InValid = 1'b0;
        step();
        step();
        OutReady = 1'b1;
        step();
        step();
        check("perf_stall3", StallCount, 3);
        check("perf_issue2", IssueCount, 2);
        OutReady = 1'b0;
        InValid = 1'b1;
        step();
        InValid = 1'b0;
        for (int i = 0; i < 70000; i++) step();
        check("perf_stall_sat", StallCount, 16'hFFFF);
        Flush = 1'b1;
        step();
        Flush = 1'b0;
        check("perf_flush_stall", StallCount, 16'hFFFF);
        check("perf_flush_issue", IssueCount, 2);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
